// File: rtl/thread_issue_if.sv
// Fetch/issue bus bundle for thread_issue.
//   imem_addr   : fetch address (issue stage -> instruction memory)
//   imem_data   : instruction word read combinationally at imem_addr
//   issue_valid : issue register holds an instruction
//   issue_ready : downstream accepts the issued instruction this cycle
//   issue_op/pc/tid/pre/pre_valid : issued instruction payload
// master = issue stage, slave = memory + downstream consumer.
interface thread_issue_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TIDW  = 1
);
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_data;
  logic             issue_valid;
  logic             issue_ready;
  logic [WIDTH-1:0] issue_op;
  logic [WIDTH-1:0] issue_pc;
  logic [TIDW-1:0]  issue_tid;
  logic [3:0]       issue_pre;
  logic             issue_pre_valid;

  modport master (
    output imem_addr, issue_valid, issue_op, issue_pc, issue_tid,
           issue_pre, issue_pre_valid,
    input  imem_data, issue_ready
  );

  modport slave (
    input  imem_addr, issue_valid, issue_op, issue_pc, issue_tid,
           issue_pre, issue_pre_valid,
    output imem_data, issue_ready
  );
endinterface

// File: rtl/thread_issue.sv
// Round-robin multithreaded fetch/issue stage with a single issue register.
// Each thread owns an interleaved PC (thread t starts at t, steps by NTHREADS),
// a halted flag and, optionally, a 4-bit prefix register.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   bus (master)          : imem_addr/imem_data fetch and issue_* handshake
//   redirect_valid/tid/pc : branch redirect from execute
//   halt_req/halt_tid     : stop one thread permanently (until reset)
//   thread_halted         : per-thread halted flags
//   halted                : all threads halted and issue register empty
// Optional feature macro: THREAD_ISSUE_PREFIX_EN -- words with [15:12]=4'hF
// are absorbed as prefixes for the next instruction of that thread.
module thread_issue #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NTHREADS = 2,
  parameter int unsigned TIDW     = 1
) (
  input  logic                clk,
  input  logic                reset,
  thread_issue_if.master      bus,
  input  logic                redirect_valid,
  input  logic [TIDW-1:0]     redirect_tid,
  input  logic [WIDTH-1:0]    redirect_pc,
  input  logic                halt_req,
  input  logic [TIDW-1:0]     halt_tid,
  output logic [NTHREADS-1:0] thread_halted,
  output logic                halted
);

  // Per-thread architectural state
  logic [WIDTH-1:0]    pc_q [NTHREADS];
  logic [NTHREADS-1:0] halt_q;
  logic [TIDW-1:0]     last_q;
  logic [WIDTH-1:0]    addr_hold_q;

  // Issue register
  logic                valid_q;
  logic [WIDTH-1:0]    op_q;
  logic [WIDTH-1:0]    ipc_q;
  logic [TIDW-1:0]     tid_q;

  logic [TIDW-1:0]     sel;
  logic [TIDW-1:0]     cand;
  logic                any_active;
  logic                fetch;
  logic                kill;
  logic                take;
  logic                absorb;

  // Round-robin pick: first non-halted thread after the last fetched one
  always_comb begin
    sel        = last_q;
    cand       = '0;
    any_active = 1'b0;
    for (int unsigned i = 1; i <= NTHREADS; i++) begin
      cand = TIDW'((32'(last_q) + i) % NTHREADS);
      if (!any_active && !halt_q[cand]) begin
        sel        = cand;
        any_active = 1'b1;
      end
    end
  end

  // A fetch is dropped when the same thread is redirected or halted this cycle
  always_comb begin
    fetch = any_active && (!valid_q || bus.issue_ready);
    kill  = (redirect_valid && (redirect_tid == sel)) ||
            (halt_req && (halt_tid == sel));
    take  = fetch && !kill;
  end

`ifdef THREAD_ISSUE_PREFIX_EN
  assign absorb = (bus.imem_data[15:12] == 4'hF);
`else
  assign absorb = 1'b0;
`endif

  // Address holds its last value once every thread is halted
  assign bus.imem_addr = any_active ? pc_q[sel] : addr_hold_q;

  // Thread PCs, halted flags, round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        pc_q[t] <= WIDTH'(t);
      end
      halt_q      <= '0;
      last_q      <= TIDW'(NTHREADS - 1);
      addr_hold_q <= '0;
    end else begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        if (redirect_valid && (redirect_tid == TIDW'(t))) begin
          pc_q[t] <= redirect_pc;
        end else if (take && (sel == TIDW'(t))) begin
          pc_q[t] <= pc_q[t] + WIDTH'(NTHREADS);
        end
      end
      if (halt_req) begin
        halt_q[halt_tid] <= 1'b1;
      end
      if (fetch) begin
        last_q <= sel;
      end
      if (any_active) begin
        addr_hold_q <= pc_q[sel];
      end
    end
  end

  // Issue register: load on a kept fetch, drain on accept, squash on redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      ipc_q   <= '0;
      tid_q   <= '0;
    end else begin
      if (take && !absorb) begin
        valid_q <= 1'b1;
        op_q    <= bus.imem_data;
        ipc_q   <= pc_q[sel];
        tid_q   <= sel;
      end else if (valid_q && bus.issue_ready) begin
        valid_q <= 1'b0;
      end else if (valid_q && redirect_valid && (tid_q == redirect_tid)) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef THREAD_ISSUE_PREFIX_EN
  logic [3:0]          pre_q [NTHREADS];
  logic [NTHREADS-1:0] pre_v_q;
  logic [3:0]          ipre_q;
  logic                ipre_v_q;

  // Prefix capture per thread; consumed by the next issued word of that thread
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        pre_q[t] <= '0;
      end
      pre_v_q  <= '0;
      ipre_q   <= '0;
      ipre_v_q <= 1'b0;
    end else begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        if (redirect_valid && (redirect_tid == TIDW'(t))) begin
          pre_v_q[t] <= 1'b0;
        end else if (take && (sel == TIDW'(t))) begin
          if (absorb) begin
            pre_q[t]   <= bus.imem_data[3:0];
            pre_v_q[t] <= 1'b1;
          end else begin
            pre_v_q[t] <= 1'b0;
          end
        end
      end
      if (take && !absorb) begin
        ipre_q   <= pre_q[sel];
        ipre_v_q <= pre_v_q[sel];
      end
    end
  end

  assign bus.issue_pre       = ipre_q;
  assign bus.issue_pre_valid = ipre_v_q;
`else
  assign bus.issue_pre       = 4'h0;
  assign bus.issue_pre_valid = 1'b0;
`endif

  assign bus.issue_valid = valid_q;
  assign bus.issue_op    = op_q;
  assign bus.issue_pc    = ipc_q;
  assign bus.issue_tid   = tid_q;
  assign thread_halted   = halt_q;
  assign halted          = (&halt_q) & ~valid_q;

endmodule
